// File: rtl/fpu_issue_stage.sv
// Issue stage in front of the FPU: queues decoded RV32F ops, issues one at a time, emits a writeback record.
// Optional watchdog on the WAIT state is enabled with `define FPU_ISSUE_TIMEOUT_EN.
module fpu_issue_stage #(
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 64
) (
  input  logic        g_clk,
  input  logic        g_rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_sel,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [31:0] in_c,
  input  logic [4:0]  in_rd,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic [31:0] fpu_c,
  output logic [4:0]  fpu_sel,
  output logic        fpu_start,
  input  logic        fpu_done,
  input  logic [31:0] fpu_res,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        busy,
  output logic        err_timeout
);

  localparam int          AW       = $clog2(DEPTH);
  localparam int          PW       = AW + 1;
  localparam logic [31:0] QNAN     = 32'h7fc00000;
  localparam logic [4:0]  SEL_IDLE = 5'b11111;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT < 1)) begin : g_bad_params
    $error("fpu_issue_stage: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]    op_sel_q, op_sel_d, op_rd_q, op_rd_d;
  logic [31:0]   op_a_q, op_a_d, op_b_q, op_b_d, op_c_q, op_c_d;
  logic [4:0]    wb_rd_q, wb_rd_d;
  logic [31:0]   wb_data_q, wb_data_d;

  logic [4:0]    sel_mem [DEPTH];
  logic [4:0]    rd_mem  [DEPTH];
  logic [31:0]   a_mem   [DEPTH];
  logic [31:0]   b_mem   [DEPTH];
  logic [31:0]   c_mem   [DEPTH];

  logic          empty, full, push, pop;
  logic [AW-1:0] wr_idx, head_idx;

`ifdef FPU_ISSUE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          err_q, err_d;
`endif

  function automatic logic is_illegal(input logic [4:0] sel);
    return (sel == 5'b00100) || (sel[4:3] == 2'b11);
  endfunction

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign wr_idx   = wr_ptr_q[AW-1:0];
  assign head_idx = rd_ptr_q[AW-1:0];
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_idx == head_idx);
  assign pop      = (state_q == S_IDLE) && !empty;
  // A pop frees a slot this cycle, so a full FIFO still accepts while IDLE.
  assign in_ready = !full || pop;
  assign push     = in_valid && in_ready;

  always_ff @(posedge g_clk) begin
    if (push) begin
      sel_mem[wr_idx] <= in_sel;
      rd_mem[wr_idx]  <= in_rd;
      a_mem[wr_idx]   <= in_a;
      b_mem[wr_idx]   <= in_b;
      c_mem[wr_idx]   <= in_c;
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    op_sel_d  = op_sel_q;
    op_rd_d   = op_rd_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    op_c_d    = op_c_q;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
`ifdef FPU_ISSUE_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
    err_d     = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          op_sel_d = sel_mem[head_idx];
          op_rd_d  = rd_mem[head_idx];
          op_a_d   = a_mem[head_idx];
          op_b_d   = b_mem[head_idx];
          op_c_d   = c_mem[head_idx];
          if (is_illegal(sel_mem[head_idx])) begin
            state_d   = S_WB;
            wb_rd_d   = rd_mem[head_idx];
            wb_data_d = QNAN;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef FPU_ISSUE_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      S_WAIT: begin
        if (fpu_done) begin
          state_d   = S_WB;
          wb_rd_d   = op_rd_q;
          wb_data_d = fpu_res;
        end
`ifdef FPU_ISSUE_TIMEOUT_EN
        else if (tmo_cnt_q == CW'(TIMEOUT - 1)) begin
          state_d   = S_WB;
          wb_rd_d   = op_rd_q;
          wb_data_d = QNAN;
          err_d     = 1'b1;
        end else if (tmo_cnt_q != {CW{1'b1}}) begin
          tmo_cnt_d = tmo_cnt_q + CW'(1);
        end
`endif
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge g_clk or posedge g_rst) begin
    if (g_rst) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      op_sel_q  <= '0;
      op_rd_q   <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      op_c_q    <= '0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      op_sel_q  <= op_sel_d;
      op_rd_q   <= op_rd_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      op_c_q    <= op_c_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

`ifdef FPU_ISSUE_TIMEOUT_EN
  always_ff @(posedge g_clk or posedge g_rst) begin
    if (g_rst) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign fpu_start = (state_q == S_ISSUE);
  assign fpu_sel   = ((state_q == S_ISSUE) || (state_q == S_WAIT)) ? op_sel_q : SEL_IDLE;
  assign fpu_a     = op_a_q;
  assign fpu_b     = op_b_q;
  assign fpu_c     = op_c_q;
  assign wb_valid  = (state_q == S_WB);
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign busy      = !empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_fpu_issue_stage.sv
// Bench for fpu_issue_stage: a stand-in FPU with programmable latency, a writeback monitor,
// and a queue model of expected writebacks in issue order.
module tb_fpu_issue_stage;
  logic        g_clk = 1'b0;
  logic        g_rst;
  logic        in_valid, in_ready;
  logic [4:0]  in_sel, in_rd;
  logic [31:0] in_a, in_b, in_c;
  logic [31:0] fpu_a, fpu_b, fpu_c, fpu_res;
  logic [4:0]  fpu_sel;
  logic        fpu_start, fpu_done;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        busy, err_timeout;

  fpu_issue_stage #(.DEPTH(2), .TIMEOUT(8)) dut (
    .g_clk(g_clk), .g_rst(g_rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_rd(in_rd),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_c(fpu_c), .fpu_sel(fpu_sel),
    .fpu_start(fpu_start), .fpu_done(fpu_done), .fpu_res(fpu_res),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 g_clk = ~g_clk;

  localparam logic [31:0] QNAN = 32'h7fc00000;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge g_clk) cyc <= cyc + 1;

  // Stand-in FPU controls and observations
  bit          fpu_hang = 0;
  bit          use_fixed = 0;
  bit          rand_lat = 0;
  int          fix_lat = 4;
  logic [31:0] fixed_res = '0;
  int          starts = 0;
  int          stable_err = 0;
  int          last_start_cyc = 0;
  int          last_push_cyc = 0;
  logic [31:0] last_a, last_b;

  // Writebacks seen and expected
  logic [4:0]  got_rd[$];
  logic [31:0] got_data[$];
  int          got_cyc[$];
  logic [4:0]  exp_rd[$];
  logic [31:0] exp_data[$];

  function automatic logic [31:0] fake_res(logic [4:0] s, logic [31:0] a, logic [31:0] b, logic [31:0] c);
    return (a + b) ^ {c[15:0], c[31:16]} ^ {27'd0, s};
  endfunction

  function automatic bit illegal_op(logic [4:0] s);
    return (s == 5'd4) || (s >= 5'd24);
  endfunction

  initial begin
    int          pend;
    logic [31:0] res, ca, cb, cc;
    logic [4:0]  cs;
    pend = 0; fpu_done = 1'b0; fpu_res = '0;
    forever begin
      @(posedge g_clk); #1;
      fpu_done = 1'b0;
      if (g_rst) pend = 0;
      else if (fpu_start === 1'b1) begin
        starts++;
        last_start_cyc = cyc;
        ca = fpu_a; cb = fpu_b; cc = fpu_c; cs = fpu_sel;
        last_a = ca; last_b = cb;
        res = use_fixed ? fixed_res : fake_res(cs, ca, cb, cc);
        pend = fpu_hang ? -1 : (rand_lat ? int'($urandom_range(1, 5)) : fix_lat);
      end else if (pend > 0) begin
        if (fpu_a !== ca || fpu_b !== cb || fpu_c !== cc || fpu_sel !== cs) stable_err++;
        pend--;
        if (pend == 0) begin fpu_done = 1'b1; fpu_res = res; end
      end
    end
  end

  initial begin
    forever begin
      @(posedge g_clk); #1;
      if (wb_valid === 1'b1) begin
        got_rd.push_back(wb_rd);
        got_data.push_back(wb_data);
        got_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic push_op(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [4:0] rd);
    int t = 0;
    in_sel = sel; in_a = a; in_b = b; in_c = c; in_rd = rd; in_valid = 1'b1;
    while (in_ready !== 1'b1 && t < 200) begin @(negedge g_clk); t++; end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL push_accept rd=%0d in_ready=%b want=1", rd, in_ready);
    end else begin
      exp_rd.push_back(rd);
      exp_data.push_back(illegal_op(sel) ? QNAN : (use_fixed ? fixed_res : fake_res(sel, a, b, c)));
    end
    @(negedge g_clk);
    last_push_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_wbs(input int target, input int budget, input string tag);
    int t = 0;
    while (got_rd.size() < target && t < budget) begin @(negedge g_clk); t++; end
    checks++;
    if (got_rd.size() < target) begin
      failures++;
      $display("FAIL %s_wb_wait got=%0d want=%0d", tag, got_rd.size(), target);
    end
  endtask

  task automatic test_reset();
    logic [31:0] act [11];
    logic [31:0] want [11];
    string nm [11] = '{"in_ready", "fpu_start", "fpu_sel", "fpu_a", "fpu_b", "fpu_c",
                       "wb_valid", "wb_rd", "wb_data", "busy", "err_timeout"};
    g_rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_a = '0; in_b = '0; in_c = '0; in_rd = '0;
    repeat (3) @(negedge g_clk);
    g_rst = 1'b0;
    @(negedge g_clk);
    act  = '{32'(in_ready), 32'(fpu_start), 32'(fpu_sel), fpu_a, fpu_b, fpu_c,
             32'(wb_valid), 32'(wb_rd), wb_data, 32'(busy), 32'(err_timeout)};
    want = '{32'd1, 32'd0, 32'h1f, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (act[i] !== want[i]) begin
        failures++;
        $display("FAIL reset_%s got=%h want=%h", nm[i], act[i], want[i]);
      end
    end
  endtask

  task automatic test_fadd();
    int base = got_rd.size();
    int s0 = starts;
    exp_rd.delete(); exp_data.delete();
    use_fixed = 1; fixed_res = 32'h40400000; fix_lat = 4; rand_lat = 0;
    push_op(5'd0, 32'h3f800000, 32'h40000000, 32'h0, 5'd5);
    wait_wbs(base + 1, 60, "fadd");
    repeat (5) @(negedge g_clk);
    use_fixed = 0;
    checks++; if (got_rd.size() != base + 1) begin failures++; $display("FAIL fadd_wb_count got=%0d want=%0d", got_rd.size() - base, 1); end
    checks++; if (got_rd[base] !== 5'd5) begin failures++; $display("FAIL fadd_wb_rd got=%0d want=5", got_rd[base]); end
    checks++; if (got_data[base] !== 32'h40400000) begin failures++; $display("FAIL fadd_wb_data got=%h want=40400000", got_data[base]); end
    checks++; if (starts - s0 != 1) begin failures++; $display("FAIL fadd_start_count got=%0d want=1", starts - s0); end
    checks++; if (last_a !== 32'h3f800000 || last_b !== 32'h40000000) begin failures++; $display("FAIL fadd_operands got=%h,%h want=3f800000,40000000", last_a, last_b); end
    checks++; if (last_start_cyc - last_push_cyc != 1) begin failures++; $display("FAIL fadd_issue_latency got=%0d want=1", last_start_cyc - last_push_cyc); end
    checks++; if (got_cyc[base] - last_start_cyc != 5) begin failures++; $display("FAIL fadd_wb_latency got=%0d want=5", got_cyc[base] - last_start_cyc); end
    checks++; if (wb_valid !== 1'b0 || wb_rd !== 5'd5 || wb_data !== 32'h40400000) begin failures++; $display("FAIL fadd_wb_hold got=%b/%0d/%h want=0/5/40400000", wb_valid, wb_rd, wb_data); end
    checks++; if (fpu_sel !== 5'h1f || busy !== 1'b0) begin failures++; $display("FAIL fadd_idle got=sel %h busy %b want=sel 1f busy 0", fpu_sel, busy); end
  endtask

  task automatic test_illegal();
    int base = got_rd.size();
    int s0 = starts;
    exp_rd.delete(); exp_data.delete();
    push_op(5'b00100, $urandom, $urandom, $urandom, 5'd7);
    push_op(5'b11111, $urandom, $urandom, $urandom, 5'd9);
    wait_wbs(base + 2, 40, "illegal");
    repeat (3) @(negedge g_clk);
    checks++; if (starts != s0) begin failures++; $display("FAIL illegal_no_start got=%0d want=0", starts - s0); end
    checks++; if (got_rd.size() != base + 2) begin failures++; $display("FAIL illegal_wb_count got=%0d want=2", got_rd.size() - base); end
    checks++; if (got_rd[base] !== 5'd7) begin failures++; $display("FAIL illegal_wb_rd got=%0d want=7", got_rd[base]); end
    checks++; if (got_data[base] !== QNAN) begin failures++; $display("FAIL illegal_wb_data got=%h want=%h", got_data[base], QNAN); end
    checks++; if (got_rd[base+1] !== 5'd9) begin failures++; $display("FAIL illegal2_wb_rd got=%0d want=9", got_rd[base+1]); end
    checks++; if (got_data[base+1] !== QNAN) begin failures++; $display("FAIL illegal2_wb_data got=%h want=%h", got_data[base+1], QNAN); end
  endtask

  task automatic test_back_to_back();
    int base = got_rd.size();
    exp_rd.delete(); exp_data.delete();
    fix_lat = 6; rand_lat = 0;
    for (int i = 1; i <= 3; i++) push_op(5'($urandom_range(0, 3)), $urandom, $urandom, $urandom, 5'(i));
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_full_ready got=%b want=0", in_ready); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy got=%b want=1", busy); end
    wait_wbs(base + 3, 100, "b2b");
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_rd[base+i] !== exp_rd[i] || got_data[base+i] !== exp_data[i]) begin
        failures++;
        $display("FAIL b2b_order_%0d got=rd %0d data %h want=rd %0d data %h", i, got_rd[base+i], got_data[base+i], exp_rd[i], exp_data[i]);
      end
    end
    repeat (3) @(negedge g_clk);
  endtask

  task automatic test_full_push_pop();
    int base = got_rd.size();
    exp_rd.delete(); exp_data.delete();
    fix_lat = 8; rand_lat = 0;
    for (int i = 10; i <= 12; i++) push_op(5'd1, $urandom, $urandom, $urandom, 5'(i));
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_ready_before got=%b want=0", in_ready); end
    push_op(5'd2, $urandom, $urandom, $urandom, 5'd13);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_ready_after got=%b want=0", in_ready); end
    wait_wbs(base + 4, 200, "full");
    repeat (5) @(negedge g_clk);
    checks++; if (got_rd.size() != base + 4) begin failures++; $display("FAIL full_wb_count got=%0d want=4", got_rd.size() - base); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got_rd[base+i] !== exp_rd[i] || got_data[base+i] !== exp_data[i]) begin
        failures++;
        $display("FAIL full_order_%0d got=rd %0d data %h want=rd %0d data %h", i, got_rd[base+i], got_data[base+i], exp_rd[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_random();
    int base = got_rd.size();
    int s0 = starts;
    int legal = 0;
    int n = 40;
    exp_rd.delete(); exp_data.delete();
    stable_err = 0; rand_lat = 1;
    for (int i = 0; i < n; i++) begin
      logic [4:0] s = 5'($urandom_range(0, 31));
      if (!illegal_op(s)) legal++;
      push_op(s, $urandom, $urandom, $urandom, 5'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge g_clk);
    end
    wait_wbs(base + n, 2000, "rand");
    repeat (10) @(negedge g_clk);
    rand_lat = 0;
    checks++; if (got_rd.size() != base + n) begin failures++; $display("FAIL rand_wb_count got=%0d want=%0d", got_rd.size() - base, n); end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_rd[base+i] !== exp_rd[i] || got_data[base+i] !== exp_data[i]) begin
        failures++;
        $display("FAIL rand_wb_%0d got=rd %0d data %h want=rd %0d data %h", i, got_rd[base+i], got_data[base+i], exp_rd[i], exp_data[i]);
      end
    end
    checks++; if (starts - s0 != legal) begin failures++; $display("FAIL rand_start_count got=%0d want=%0d", starts - s0, legal); end
    checks++; if (stable_err != 0) begin failures++; $display("FAIL rand_operand_stable got=%0d want=0", stable_err); end
  endtask

  task automatic test_timeout();
    int base = got_rd.size();
    exp_rd.delete(); exp_data.delete();
    fpu_hang = 1;
    push_op(5'd1, 32'h12345678, 32'h9abcdef0, 32'h0, 5'd20);
`ifdef FPU_ISSUE_TIMEOUT_EN
    wait_wbs(base + 1, 40, "timeout");
    @(negedge g_clk);
    checks++; if (err_timeout !== 1'b1) begin failures++; $display("FAIL timeout_err got=%b want=1", err_timeout); end
    checks++; if (got_data[base] !== QNAN || got_rd[base] !== 5'd20) begin failures++; $display("FAIL timeout_wb got=rd %0d data %h want=rd 20 data %h", got_rd[base], got_data[base], QNAN); end
    checks++; if (got_cyc[base] - last_start_cyc != 9) begin failures++; $display("FAIL timeout_latency got=%0d want=9", got_cyc[base] - last_start_cyc); end
    repeat (3) @(negedge g_clk);
    checks++; if (err_timeout !== 1'b1) begin failures++; $display("FAIL timeout_sticky got=%b want=1", err_timeout); end
`else
    repeat (100) @(negedge g_clk);
    checks++; if (got_rd.size() != base) begin failures++; $display("FAIL notimeout_wb got=%0d want=0", got_rd.size() - base); end
    checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL notimeout_err got=%b want=0", err_timeout); end
    checks++; if (fpu_sel !== 5'd1 || fpu_start !== 1'b0) begin failures++; $display("FAIL notimeout_wait got=sel %h start %b want=sel 01 start 0", fpu_sel, fpu_start); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL notimeout_busy got=%b want=1", busy); end
`endif
  endtask

  task automatic test_reset_mid_wait();
    int base;
    int s0;
    logic [31:0] act [11];
    logic [31:0] want [11];
    string nm [11] = '{"in_ready", "fpu_start", "fpu_sel", "fpu_a", "fpu_b", "fpu_c",
                       "wb_valid", "wb_rd", "wb_data", "busy", "err_timeout"};
    fpu_hang = 1;
    push_op(5'd3, 32'hdeadbeef, 32'h01020304, 32'h55aa55aa, 5'd21);
    repeat (4) @(negedge g_clk);
    @(posedge g_clk); #2;
    g_rst = 1'b1;
    #1;
    act  = '{32'(in_ready), 32'(fpu_start), 32'(fpu_sel), fpu_a, fpu_b, fpu_c,
             32'(wb_valid), 32'(wb_rd), wb_data, 32'(busy), 32'(err_timeout)};
    want = '{32'd1, 32'd0, 32'h1f, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (act[i] !== want[i]) begin
        failures++;
        $display("FAIL async_reset_%s got=%h want=%h", nm[i], act[i], want[i]);
      end
    end
    base = got_rd.size();
    repeat (2) @(negedge g_clk);
    g_rst = 1'b0; fpu_hang = 0;
    s0 = starts;
    repeat (20) @(negedge g_clk);
    checks++; if (got_rd.size() != base) begin failures++; $display("FAIL async_reset_no_wb got=%0d want=0", got_rd.size() - base); end
    checks++; if (starts != s0) begin failures++; $display("FAIL async_reset_no_issue got=%0d want=0", starts - s0); end
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL async_reset_idle got=busy %b ready %b want=busy 0 ready 1", busy, in_ready); end
  endtask

  initial begin
    test_reset();
    test_fadd();
    test_illegal();
    test_back_to_back();
    test_full_push_pop();
    test_random();
    test_timeout();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
